// File: rtl/mips_core.sv
// mips_core: 5-stage MIPS subset pipeline (add/sub/and/or/slt/addi/lw/sw) with EX forwarding.
// Define MIPS_CORE_BEQ_EN to resolve beq in EX with a two-bubble flush; otherwise beq is a NOP.
module mips_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instructionInput,
  input  logic        instructionWriteEnable,
  input  logic [10:0] writeAddr,
  input  logic [31:0] PC,
  input  logic        PC_set,
  output logic [31:0] ALU_result,
  output logic [31:0] writeDataReg_WB,
  output logic [31:0] instruction_ID,
  output logic [31:0] readData1_EX,
  output logic [31:0] readData2_EX,
  output logic [31:0] PC_ID,
  output logic [31:0] PC_incr4_ID,
  output logic [31:0] PC_incr4_EX,
  output logic        MemtoReg_MEM,
  output logic        RegWrite_MEM,
  output logic        RegWrite_ID,
  output logic [4:0]  writeAddr_WB,
  output logic [4:0]  writeAddr_EX,
  output logic [4:0]  writeAddr_ID
);
  logic [31:0] imem [0:2047];
  logic [31:0] dmem [0:255];
  logic [31:0] regFile [0:31];
  logic [31:0] pcReg;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic        isRtype, memReadID, memWriteID, aluSrcID, isBeqID;
  logic [2:0]  aluCtlID;
  logic [31:0] immID, rd1ID, rd2ID;
  logic [31:0] rd1EX, rd2EX, immEX, aluB, branchTarget;
  logic [4:0]  rsEX, rtEX;
  logic [2:0]  aluCtlEX;
  logic        aluSrcEX, regWriteEX, memtoRegEX, memWriteEX, isBeqEX, branchTaken, bubble;
  logic [31:0] aluResMEM, storeDataMEM;
  logic [4:0]  writeAddrMEM;
  logic        memWriteMEM;
  logic [31:0] aluResWB, memDataWB;
  logic        memtoRegWB, regWriteWB;

  assign opcode = instruction_ID[31:26];
  assign rs     = instruction_ID[25:21];
  assign rt     = instruction_ID[20:16];
  assign rd     = instruction_ID[15:11];
  assign funct  = instruction_ID[5:0];
  assign immID  = {{16{instruction_ID[15]}}, instruction_ID[15:0]};
  assign isRtype = opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22 || funct == 6'h24 ||
                                       funct == 6'h25 || funct == 6'h2A);
  assign memReadID   = opcode == 6'h23;
  assign memWriteID  = opcode == 6'h2B;
  assign aluSrcID    = opcode == 6'h08 || memReadID || memWriteID;
  assign RegWrite_ID = isRtype || opcode == 6'h08 || memReadID;
  assign writeAddr_ID = opcode == 6'h00 ? rd : rt;
  assign aluCtlID = !isRtype ? 3'd0 : funct == 6'h22 ? 3'd1 : funct == 6'h24 ? 3'd2 :
                    funct == 6'h25 ? 3'd3 : funct == 6'h2A ? 3'd4 : 3'd0;
`ifdef MIPS_CORE_BEQ_EN
  assign isBeqID = opcode == 6'h04;
`else
  assign isBeqID = 1'b0;
`endif

  // WB-to-ID bypass makes a same-cycle write visible to the decoding instruction
  assign rd1ID = (regWriteWB && writeAddr_WB != 5'd0 && writeAddr_WB == rs) ? writeDataReg_WB : regFile[rs];
  assign rd2ID = (regWriteWB && writeAddr_WB != 5'd0 && writeAddr_WB == rt) ? writeDataReg_WB : regFile[rt];

  assign readData1_EX = (RegWrite_MEM && rsEX != 5'd0 && writeAddrMEM == rsEX) ? aluResMEM :
                        (regWriteWB && rsEX != 5'd0 && writeAddr_WB == rsEX) ? writeDataReg_WB : rd1EX;
  assign readData2_EX = (RegWrite_MEM && rtEX != 5'd0 && writeAddrMEM == rtEX) ? aluResMEM :
                        (regWriteWB && rtEX != 5'd0 && writeAddr_WB == rtEX) ? writeDataReg_WB : rd2EX;
  assign aluB = aluSrcEX ? immEX : readData2_EX;
  assign ALU_result = aluCtlEX == 3'd1 ? readData1_EX - aluB :
                      aluCtlEX == 3'd2 ? readData1_EX & aluB :
                      aluCtlEX == 3'd3 ? readData1_EX | aluB :
                      aluCtlEX == 3'd4 ? {31'd0, $signed(readData1_EX) < $signed(aluB)} :
                      readData1_EX + aluB;
  assign branchTaken  = isBeqEX && readData1_EX == readData2_EX;
  assign branchTarget = PC_incr4_EX + {immEX[29:0], 2'b00};
  assign bubble = PC_set || branchTaken;
  assign writeDataReg_WB = memtoRegWB ? memDataWB : aluResWB;

  always_ff @(posedge clk) begin
    if (instructionWriteEnable) imem[writeAddr] <= instructionInput;
    if (memWriteMEM) dmem[aluResMEM[9:2]] <= storeDataMEM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg <= '0;
      {instruction_ID, PC_ID, PC_incr4_ID} <= '0;
      {rd1EX, rd2EX, immEX, rsEX, rtEX, aluCtlEX, aluSrcEX, regWriteEX, memtoRegEX, memWriteEX, isBeqEX} <= '0;
      {writeAddr_EX, PC_incr4_EX} <= '0;
      {aluResMEM, storeDataMEM, writeAddrMEM, RegWrite_MEM, MemtoReg_MEM, memWriteMEM} <= '0;
      {aluResWB, memDataWB, writeAddr_WB, regWriteWB, memtoRegWB} <= '0;
      for (int i = 0; i < 32; i++) regFile[i] <= '0;
    end else begin
      pcReg <= PC_set ? PC : branchTaken ? branchTarget : pcReg + 32'd4;
      instruction_ID <= bubble ? '0 : imem[pcReg[12:2]];
      PC_ID          <= bubble ? '0 : pcReg;
      PC_incr4_ID    <= bubble ? '0 : pcReg + 32'd4;
      {rd1EX, rd2EX, immEX, rsEX, rtEX, aluCtlEX, aluSrcEX, regWriteEX, memtoRegEX, memWriteEX, isBeqEX} <= bubble ? '0 :
        {rd1ID, rd2ID, immID, rs, rt, aluCtlID, aluSrcID, RegWrite_ID, memReadID, memWriteID, isBeqID};
      {writeAddr_EX, PC_incr4_EX} <= bubble ? '0 : {writeAddr_ID, PC_incr4_ID};
      {aluResMEM, storeDataMEM, writeAddrMEM, RegWrite_MEM, MemtoReg_MEM, memWriteMEM} <= PC_set ? '0 :
        {ALU_result, readData2_EX, writeAddr_EX, regWriteEX, memtoRegEX, memWriteEX};
      {aluResWB, memDataWB, writeAddr_WB, regWriteWB, memtoRegWB} <= PC_set ? '0 :
        {aluResMEM, dmem[aluResMEM[9:2]], writeAddrMEM, RegWrite_MEM, MemtoReg_MEM};
      if (regWriteWB && writeAddr_WB != 5'd0) regFile[writeAddr_WB] <= writeDataReg_WB;
    end
  end
endmodule

// File: tb/tb_mips_core.sv
// tb_mips_core: directed program tests for mips_core with hand-computed results.
module tb_mips_core;
  logic        clk = 0, rst_n = 0;
  logic [31:0] instructionInput = 0, PC = 0;
  logic        instructionWriteEnable = 0, PC_set = 0;
  logic [10:0] writeAddr = 0;
  logic [31:0] ALU_result, writeDataReg_WB, instruction_ID, readData1_EX, readData2_EX;
  logic [31:0] PC_ID, PC_incr4_ID, PC_incr4_EX;
  logic        MemtoReg_MEM, RegWrite_MEM, RegWrite_ID;
  logic [4:0]  writeAddr_WB, writeAddr_EX, writeAddr_ID;
  logic [31:0] prog [$];
  int total = 0, bad = 0;

  mips_core dut (
    .clk(clk), .rst_n(rst_n), .instructionInput(instructionInput),
    .instructionWriteEnable(instructionWriteEnable), .writeAddr(writeAddr), .PC(PC), .PC_set(PC_set),
    .ALU_result(ALU_result), .writeDataReg_WB(writeDataReg_WB), .instruction_ID(instruction_ID),
    .readData1_EX(readData1_EX), .readData2_EX(readData2_EX), .PC_ID(PC_ID), .PC_incr4_ID(PC_incr4_ID),
    .PC_incr4_EX(PC_incr4_EX), .MemtoReg_MEM(MemtoReg_MEM), .RegWrite_MEM(RegWrite_MEM),
    .RegWrite_ID(RegWrite_ID), .writeAddr_WB(writeAddr_WB), .writeAddr_EX(writeAddr_EX),
    .writeAddr_ID(writeAddr_ID)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the pipeline at PC 0 while writing the program (zero-padded to 32 words)
  task automatic load_prog();
    PC_set = 1;
    PC = 0;
    for (int i = 0; i < 32; i++) begin
      instructionWriteEnable = 1;
      writeAddr = 11'(i);
      instructionInput = i < prog.size() ? prog[i] : 32'h0;
      step(1);
    end
    instructionWriteEnable = 0;
    PC_set = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    rst_n = 1;
  endtask

  initial begin
    #1;
    chk("rst_alu", ALU_result, 0);
    chk("rst_wbdata", writeDataReg_WB, 0);
    chk("rst_instr", instruction_ID, 0);
    chk("rst_pc4id", PC_incr4_ID, 0);
    chk("rst_ctl", {27'd0, MemtoReg_MEM, RegWrite_MEM, RegWrite_ID, 2'd0}, 0);
    rst_n = 1;

    prog = '{32'h00000820, 32'h201d03fc, 32'h2010000f, 32'h20110009, 32'h0,
             32'h02119020, 32'h0, 32'hac120064, 32'h0};
    load_prog();
    step(7);
    chk("p1_add_alu", ALU_result, 32'h18);
    chk("p1_add_a", readData1_EX, 32'hF);
    chk("p1_add_b", readData2_EX, 32'h9);
    step(1);
    chk("p1_regwr_mem", {31'd0, RegWrite_MEM}, 1);
    step(1);
    chk("p1_wbdata", writeDataReg_WB, 32'h18);
    chk("p1_wbaddr", {27'd0, writeAddr_WB}, 18);
    step(6);
    chk("p1_r1", dut.regFile[1], 0);
    chk("p1_r29", dut.regFile[29], 32'h3FC);
    chk("p1_r16", dut.regFile[16], 32'hF);
    chk("p1_r17", dut.regFile[17], 32'h9);
    chk("p1_r18", dut.regFile[18], 32'h18);
    chk("p1_dmem25", dut.dmem[25], 32'h18);

    do_reset();
    prog = '{32'h20080005, 32'h01084820};
    load_prog();
    step(1);
    chk("p2_instr", instruction_ID, 32'h20080005);
    chk("p2_regwr_id", {31'd0, RegWrite_ID}, 1);
    chk("p2_wa_id0", {27'd0, writeAddr_ID}, 8);
    step(1);
    chk("p2_pc_id", PC_ID, 4);
    chk("p2_pc4_id", PC_incr4_ID, 8);
    chk("p2_pc4_ex", PC_incr4_EX, 4);
    chk("p2_wa_id1", {27'd0, writeAddr_ID}, 9);
    chk("p2_wa_ex", {27'd0, writeAddr_EX}, 8);
    step(1);
    chk("p2_fwd_a", readData1_EX, 5);
    chk("p2_fwd_b", readData2_EX, 5);
    chk("p2_alu", ALU_result, 10);
    step(5);
    chk("p2_r8", dut.regFile[8], 5);
    chk("p2_r9", dut.regFile[9], 10);

    do_reset();
    prog = '{32'h20080077, 32'h2009000C, 32'hAD28FFFC, 32'h8D2AFFFC, 32'h0, 32'h01405820};
    load_prog();
    step(6);
    chk("p3_memtoreg", {31'd0, MemtoReg_MEM}, 1);
    step(6);
    chk("p3_dmem2", dut.dmem[2], 32'h77);
    chk("p3_r10", dut.regFile[10], 32'h77);
    chk("p3_r11", dut.regFile[11], 32'h77);

    do_reset();
    prog = '{32'h2001FFFD, 32'h20020005, 32'h00221822, 32'h00222024, 32'h00222825,
             32'h0022302A, 32'h0041382A, 32'h20000007, 32'h340C0001};
    load_prog();
    step(16);
    chk("p4_r1", dut.regFile[1], 32'hFFFFFFFD);
    chk("p4_sub", dut.regFile[3], 32'hFFFFFFF8);
    chk("p4_and", dut.regFile[4], 32'h5);
    chk("p4_or", dut.regFile[5], 32'hFFFFFFFD);
    chk("p4_slt1", dut.regFile[6], 1);
    chk("p4_slt0", dut.regFile[7], 0);
    chk("p4_r0", dut.regFile[0], 0);
    chk("p4_ori_nop", dut.regFile[12], 0);

    PC_set = 1;
    step(1);
    PC_set = 0;
    step(3);
    #2;
    rst_n = 0;
    #1;
    chk("mr_instr", instruction_ID, 0);
    chk("mr_alu", ALU_result, 0);
    chk("mr_pcid", PC_ID, 0);
    chk("mr_rd1", readData1_EX, 0);
    chk("mr_wa", {writeAddr_WB, writeAddr_EX, writeAddr_ID, 17'd0}, 0);
    chk("mr_r1", dut.regFile[1], 0);
    rst_n = 1;
    step(1);
    chk("mr_restart", instruction_ID, 32'h2001FFFD);
    chk("mr_restart_pc", PC_ID, 0);

    do_reset();
    prog = '{32'h10000002, 32'h20010001, 32'h20020002, 32'h20030003};
    load_prog();
    step(10);
`ifdef MIPS_CORE_BEQ_EN
    chk("beq_r1", dut.regFile[1], 0);
    chk("beq_r2", dut.regFile[2], 0);
`else
    chk("beq_r1", dut.regFile[1], 1);
    chk("beq_r2", dut.regFile[2], 2);
`endif
    chk("beq_r3", dut.regFile[3], 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_core.md
MIPS_CORE -- requirements
Module: mips_core

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: instructionInput  in  32  word to load into instruction memory.
REQ-004 SHALL have port: instructionWriteEnable  in  1  instruction-memory write strobe.
REQ-005 SHALL have port: writeAddr  in  11  instruction-memory word address.
REQ-006 SHALL have port: PC  in  32  byte address loaded into the PC register.
REQ-007 SHALL have port: PC_set  in  1  load PC and hold the pipeline.
REQ-008 SHALL have outputs, all in output port order: ALU_result (32, EX ALU output), writeDataReg_WB (32, WB write data), instruction_ID (32), readData1_EX and readData2_EX (32, post-forwarding EX operands), PC_ID (32), PC_incr4_ID (32), PC_incr4_EX (32), MemtoReg_MEM (1), RegWrite_MEM (1), RegWrite_ID (1), writeAddr_WB (5), writeAddr_EX (5), writeAddr_ID (5).

Function
REQ-009 SHALL implement a 5-stage IF/ID/EX/MEM/WB pipeline with 2048x32 instruction memory and 256x32 data memory.
REQ-010 SHALL write instructionInput to imem[writeAddr] at the clock edge when instructionWriteEnable=1, independent of PC_set; a same-cycle fetch of that address returns the old word.
REQ-011 While PC_set=1, the PC register SHALL load PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers SHALL load NOP (32'h0, all controls 0).
REQ-012 With PC_set=0, the IF/ID register SHALL latch imem[PC[12:2]] and the PC register SHALL advance by 4 each cycle.
REQ-013 The first edge after PC_set falls SHALL place the instruction at the loaded PC into ID.
REQ-014 The core SHALL support add, sub, and, or and slt (funct 0x20/0x22/0x24/0x25/0x2A), addi (0x08), lw (0x23) and sw (0x2B); all other opcodes SHALL execute as NOP.
REQ-015 addi, lw and sw SHALL sign-extend the 16-bit immediate; arithmetic SHALL be 32-bit wrap-around with no overflow trap; slt SHALL compare signed.
REQ-016 writeAddr_ID SHALL be rd for R-type and rt for I-type; RegWrite_ID=1 SHALL apply only to the R-type ops, addi and lw.
REQ-017 Writes to register $0 SHALL be discarded, and $0 SHALL read 0.
REQ-018 The register file SHALL write in WB; a same-cycle ID read of the written register SHALL return the new value.
REQ-019 EX SHALL forward from EX/MEM first, then MEM/WB, when the source register is non-zero and RegWrite=1.
REQ-020 There SHALL be no load-use interlock; software inserts one NOP after lw.
REQ-021 The data-memory word address SHALL be ALU_result[9:2]; sw SHALL write in MEM; lw data SHALL be selected in WB when MemtoReg=1.
REQ-022 PC_incr4_ID SHALL equal PC_ID+4; PC_incr4_EX SHALL be the same value delayed one stage.

Reset
REQ-023 rst_n=0 SHALL asynchronously clear the PC, all pipeline registers (NOP) and all 32 registers to 0, so every output reads 0; memory contents SHALL be preserved.
REQ-024 Reset asserted mid-program SHALL discard all in-flight instructions; execution SHALL restart at PC 0 after release unless PC_set is asserted.

Configuration
REQ-025 MIPS_CORE_BEQ_EN defined: beq (0x04) SHALL be resolved in EX; if taken, PC SHALL become PC_incr4_EX+(simm<<2) and IF/ID and ID/EX SHALL be flushed (2 bubbles).
REQ-026 MIPS_CORE_BEQ_EN undefined: beq SHALL execute as NOP.

Verification
REQ-027 Load program 00000820, 201d03fc, 2010000f, 20110009, 0, 02119020, 0, ac120064, 0 at words 0-8 under PC_set=1 with PC=0, then release -> $1=0, $29=0x3FC, $16=0xF, $17=9; ALU_result=0x18 when add is in EX; writeDataReg_WB=0x18 with writeAddr_WB=18; dmem[25]=0x18.
REQ-028 Back-to-back addi $8,$0,5; add $9,$8,$8 with no NOP -> readData1_EX=readData2_EX=5; $9=10.
REQ-029 sw then lw $10 of the same address plus one NOP -> $10 equals the stored value; MemtoReg_MEM=1 during lw in MEM.
REQ-030 Assert rst_n=0 mid-program -> all outputs 0 immediately; imem preserved; after release instruction_ID=imem[0] on the first edge.
REQ-031 With MIPS_CORE_BEQ_EN, beq $0,$0,+2 -> the two following instructions do not write; the target executes.
